// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared pipeline control types and defaults
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam int unsigned MEM_TIMEOUT_DEF = 16;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned STALL_W         = 16;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard between execute-stage load and decode sources
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             id_exe_memread_i,
    input  logic [REG_W-1:0] id_exe_rt_i,
    input  logic [REG_W-1:0] if_id_rs_i,
    input  logic [REG_W-1:0] if_id_rt_i,
    output logic             hazard_o
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard_o = id_exe_memread_i
                    && (id_exe_rt_i != '0)
                    && ((id_exe_rt_i == if_id_rs_i) || (id_exe_rt_i == if_id_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush control for branches, load-use and slow data memory
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REG_W-1:0]   IF_ID_Rs,
    input  logic [REG_W-1:0]   IF_ID_Rt,
    input  logic [REG_W-1:0]   ID_EXE_Rt,
    input  logic               ID_EXE_MemRead,
    input  logic               EXE_MEM_BranchEqual,
    input  logic               EXE_MEM_BranchnotEqual,
    input  logic               EXE_MEM_Zero,
    input  logic               EXE_MEM_MemRead,
    input  logic               EXE_MEM_MemWrite,
    input  logic               mem_ready,
    output logic               PC_Write,
    output logic               IF_ID_Write,
    output logic               ID_EXE_Write,
    output logic               EXE_MEM_Write,
    output logic               IF_ID_Flush,
    output logic               ID_EXE_Flush,
    output logic               EXE_MEM_Flush,
    output logic               PCSrc,
    output logic               mem_req,
    output logic               mem_error,
    output logic [STALL_W-1:0] stall_count
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               taken;
    logic               hazard;

    load_use_detect u_load_use_detect (
        .id_exe_memread_i (ID_EXE_MemRead),
        .id_exe_rt_i      (ID_EXE_Rt),
        .if_id_rs_i       (IF_ID_Rs),
        .if_id_rt_i       (IF_ID_Rt),
        .hazard_o         (hazard)
    );

    assign taken   = (EXE_MEM_BranchEqual & EXE_MEM_Zero) | (EXE_MEM_BranchnotEqual & ~EXE_MEM_Zero);
    assign mem_req = EXE_MEM_MemRead | EXE_MEM_MemWrite;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EXE_Write  = 1'b1;
        EXE_MEM_Write = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EXE_Flush  = 1'b0;
        EXE_MEM_Flush = 1'b0;
        PCSrc         = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (taken) begin
                    PCSrc         = 1'b1;
                    IF_ID_Flush   = 1'b1;
                    ID_EXE_Flush  = 1'b1;
                    EXE_MEM_Flush = 1'b1;
                end else if (mem_req && !mem_ready) begin
                    PC_Write      = 1'b0;
                    IF_ID_Write   = 1'b0;
                    ID_EXE_Write  = 1'b0;
                    EXE_MEM_Write = 1'b0;
                    state_d       = ST_MEM_WAIT;
                    cnt_d         = CNT_W'(1);
                end else if (hazard) begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EXE_Flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EXE_Write  = 1'b0;
                EXE_MEM_Write = 1'b0;
                // completion wins over a coinciding timeout
                if (mem_ready) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d       = ST_RUN;
                    cnt_d         = '0;
                    err_d         = 1'b1;
                    EXE_MEM_Flush = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if ((!PC_Write || !EXE_MEM_Write) && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign mem_error   = err_q;
    assign stall_count = stall_q;

endmodule
